// File: rtl/break_pkg.sv
// Shared types for the break-away LED sequencer: LED count, frame type and FSM states.
package break_pkg;

  localparam int LED_COUNT = 5;

  typedef logic [LED_COUNT-1:0] led_frame_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW
  } seq_state_t;

endpackage

// File: rtl/led_frame_fifo.sv
// First-word-fall-through FIFO of {frame, duration} entries; pushes while full and pops while empty are ignored.
module led_frame_fifo
  import break_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DUR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [LED_COUNT-1:0] wr_frame,
  input  logic [DUR_W-1:0]     wr_dur,
  input  logic                 pop,
  output logic [LED_COUNT-1:0] rd_frame,
  output logic [DUR_W-1:0]     rd_dur,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);

  led_frame_t       frame_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem   [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rd_frame = frame_mem[rd_ptr[AW-1:0]];
  assign rd_dur   = dur_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      frame_mem[wr_ptr[AW-1:0]] <= wr_frame;
      dur_mem[wr_ptr[AW-1:0]]   <= wr_dur;
    end
  end

endmodule

// File: rtl/break_led_sequencer.sv
// Plays buffered LED frames on the break-away LEDs for exact tick counts.
// Optional PWM dimming with a brightness input when BREAK_LED_PWM_EN is defined.
module break_led_sequencer
  import break_pkg::*;
#(
  parameter int TICK_DIV   = 12000,
  parameter int FIFO_DEPTH = 4,
  parameter int DUR_W      = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [LED_COUNT-1:0] i_frame,
  input  logic [DUR_W-1:0]     i_duration,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [LED_COUNT-1:0] o_leds,
  output logic                 o_busy
`ifdef BREAK_LED_PWM_EN
  ,
  input  logic [3:0]           i_brightness
`endif
);

  localparam int               PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_PEN  = PRE_W'(TICK_DIV - 2);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

  seq_state_t       state;
  logic [PRE_W-1:0] pre;
  logic [DUR_W-1:0] cnt;
  led_frame_t       cur_frame;
  led_frame_t       hold_frame;
  logic [DUR_W-1:0] hold_dur;
  led_frame_t       rd_frame;
  logic [DUR_W-1:0] rd_dur;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ready_q;
  logic             last_tick;
  logic             end_tick;

  assign push    = i_valid && ready_q;
  assign o_ready = ready_q;
  assign o_busy  = (state != IDLE) || !empty;

  // The next frame is popped one cycle before the final tick ends so the LOAD
  // cycle still belongs to the outgoing frame and back-to-back frames abut.
  assign last_tick = (cnt == DUR_ONE) && ((pre == PRE_PEN) || (pre == PRE_LAST));
  assign end_tick  = (cnt == DUR_ONE) && (pre == PRE_LAST);

  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = !empty;
      SHOW:    pop = !empty && ((cnt == '0) || last_tick);
      default: pop = 1'b0;
    endcase
  end

  led_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DUR_W (DUR_W)
  ) u_fifo (
    .clk      (i_clock),
    .rst_n    (i_reset_n),
    .push     (push),
    .wr_frame (i_frame),
    .wr_dur   (i_duration),
    .pop      (pop),
    .rd_frame (rd_frame),
    .rd_dur   (rd_dur),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge i_clock) begin
    if (pop) begin
      hold_frame <= rd_frame;
      hold_dur   <= rd_dur;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      pre       <= '0;
      cnt       <= '0;
      cur_frame <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= !full;
      unique case (state)
        IDLE: begin
          if (pop) state <= LOAD;
        end
        LOAD: begin
          cur_frame <= hold_frame;
          cnt       <= hold_dur;
          pre       <= '0;
          state     <= SHOW;
        end
        SHOW: begin
          pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
          if ((pre == PRE_LAST) && (cnt != '0)) cnt <= cnt - 1'b1;
          if (pop)           state <= LOAD;
          else if (end_tick) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BREAK_LED_PWM_EN
  logic [3:0] pwm_cnt;
  led_frame_t leds_q;
  led_frame_t frame_next;

  // Mask the frame that the FSM is about to show so dimming adds no latency.
  assign frame_next = (state == LOAD) ? hold_frame : cur_frame;
  assign o_leds     = leds_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_cnt <= '0;
      leds_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      leds_q  <= frame_next & {LED_COUNT{pwm_cnt < i_brightness}};
    end
  end
`else
  assign o_leds = cur_frame;
`endif

endmodule

// File: tb/tb_break_led_sequencer.sv
// Scoreboard bench for break_led_sequencer with TICK_DIV=4, FIFO_DEPTH=4.
module tb_break_led_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] frame;
  logic [7:0] duration;
  logic       valid;
  logic       ready;
  logic [4:0] leds;
  logic       busy;
`ifdef BREAK_LED_PWM_EN
  logic [3:0] brightness = 4'd4;
`endif

  break_led_sequencer #(
    .TICK_DIV   (4),
    .FIFO_DEPTH (4),
    .DUR_W      (8)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (reset_n),
    .i_frame      (frame),
    .i_duration   (duration),
    .i_valid      (valid),
    .o_ready      (ready),
    .o_leds       (leds),
    .o_busy       (busy)
`ifdef BREAK_LED_PWM_EN
    ,
    .i_brightness (brightness)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] frame;
    int         cycles;
    int         appear;
  } exp_t;

  exp_t       sbq[$];
  exp_t       cur;
  bit         cur_open = 0;
  bit         mon_en = 0;
  int         run = 0;
  logic [4:0] last_leds = '0;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every change on the LEDs is a newly presented frame.
  always @(negedge clk) begin
    if (!mon_en) begin
      last_leds = leds;
      cur_open  = 0;
      run       = 0;
    end else if (leds !== last_leds) begin
      if (cur_open && cur.cycles > 0)
        chk(run == cur.cycles, "frame_length", run, cur.cycles);
      chk(sbq.size() != 0, "unexpected_frame", int'(leds), -1);
      if (sbq.size() != 0) begin
        cur = sbq.pop_front();
        chk(leds == cur.frame, "frame_value", int'(leds), int'(cur.frame));
        if (cur.appear >= 0)
          chk(cyc == cur.appear, "frame_latency", cyc, cur.appear);
        cur_open = 1;
      end else begin
        cur_open = 0;
      end
      run       = 1;
      last_leds = leds;
    end else begin
      run++;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_frame(input logic [4:0] f, input logic [7:0] d, input bit shown,
                            input int cycles, input bit known_lat, output int acc);
    int w = 0;
    frame    = f;
    duration = d;
    valid    = 1'b1;
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk(ready, "push_accept", int'(ready), 1);
    acc = cyc + 1;
    if (shown) sbq.push_back('{f, cycles, known_lat ? acc + 2 : -1});
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk(!busy, "idle_timeout", int'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  int a, a1, dummy, hold_cnt;
  int on_cnt[5];

  initial begin
    reset_n  = 1'b0;
    valid    = 1'b0;
    frame    = '0;
    duration = '0;
    #2;
    chk(leds == 5'b0, "reset_leds", int'(leds), 0);
    chk(ready == 1'b0, "reset_ready", int'(ready), 0);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk(ready == 1'b1, "ready_after_release", int'(ready), 1);

`ifdef BREAK_LED_PWM_EN
    push_frame(5'b11111, 8'd0, 1'b0, 0, 1'b0, a);
    wait_until(a + 4);
    for (int i = 0; i < 64; i++) begin
      for (int b = 0; b < 5; b++) if (leds[b]) on_cnt[b]++;
      @(negedge clk);
    end
    for (int b = 0; b < 5; b++) chk(on_cnt[b] == 16, "pwm_duty", on_cnt[b], 16);
`else
    mon_en = 1;

    // Single timed frame from idle.
    push_frame(5'b10101, 8'd3, 1'b1, 0, 1'b1, a);
    wait_until(a + 2 + 11);
    chk(busy == 1'b1, "single_busy_last", int'(busy), 1);
    wait_until(a + 2 + 12);
    chk(busy == 1'b0, "single_busy_end", int'(busy), 0);
    chk(leds == 5'b10101, "single_hold", int'(leds), 21);
    wait_idle();

    // Back-to-back frames: lengths 4, 8, 4 with no gap.
    push_frame(5'b00001, 8'd1, 1'b1, 4, 1'b1, a1);
    push_frame(5'b00010, 8'd2, 1'b1, 8, 1'b0, dummy);
    push_frame(5'b00100, 8'd1, 1'b1, 0, 1'b0, dummy);
    wait_until(a1 + 17);
    chk(busy == 1'b1, "b2b_busy_last", int'(busy), 1);
    wait_until(a1 + 18);
    chk(busy == 1'b0, "b2b_busy_end", int'(busy), 0);
    wait_idle();

    // Fill the FIFO with valid held high.
    push_frame(5'b00011, 8'd2, 1'b1, 8, 1'b1, a1);
    push_frame(5'b00110, 8'd1, 1'b1, 4, 1'b0, dummy);
    push_frame(5'b01100, 8'd1, 1'b1, 4, 1'b0, dummy);
    push_frame(5'b11000, 8'd1, 1'b1, 4, 1'b0, dummy);
    push_frame(5'b10001, 8'd1, 1'b1, 0, 1'b0, dummy);
    wait_until(a1 + 5);
    chk(ready == 1'b0, "full_ready_drop", int'(ready), 0);
    wait_until(a1 + 9);
    chk(ready == 1'b0, "full_ready_low", int'(ready), 0);
    wait_until(a1 + 10);
    chk(ready == 1'b1, "full_ready_return", int'(ready), 1);
    wait_idle();

    // Duration 0 holds until the next frame arrives.
    push_frame(5'b11111, 8'd0, 1'b1, 0, 1'b1, a);
    wait_until(a + 2);
    hold_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (leds == 5'b11111) hold_cnt++;
      @(negedge clk);
    end
    chk(hold_cnt == 50, "dur0_hold", hold_cnt, 50);
    push_frame(5'b00000, 8'd1, 1'b1, 0, 1'b1, dummy);
    wait_idle();

    // Reset in the middle of a frame with two frames queued.
    push_frame(5'b01010, 8'd3, 1'b1, 0, 1'b1, a);
    push_frame(5'b10000, 8'd1, 1'b0, 0, 1'b0, dummy);
    push_frame(5'b00101, 8'd1, 1'b0, 0, 1'b0, dummy);
    wait_until(a + 5);
    #2;
    mon_en  = 0;
    reset_n = 1'b0;
    #1;
    chk(leds == 5'b0, "midreset_leds", int'(leds), 0);
    chk(ready == 1'b0, "midreset_ready", int'(ready), 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk(ready == 1'b1, "postreset_ready", int'(ready), 1);
    chk(busy == 1'b0, "postreset_busy", int'(busy), 0);
    mon_en = 1;
    repeat (40) @(negedge clk);
    chk(leds == 5'b0, "postreset_dark", int'(leds), 0);
`endif

    chk(sbq.size() == 0, "scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
